// File: rtl/stream_capture_slave_if.sv
// ============================================================================
// Module   : stream_capture_slave_if
// Brief    : AXI-Stream signal bundle between a stream master and capture slave
// Revision : 1.0
// ============================================================================
`default_nettype none

interface stream_capture_slave_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] S_AXI_TDATA;
  logic                  S_AXI_TVALID;
  logic                  S_AXI_TREADY;
  logic                  S_AXI_TLAST;

  modport master (
    output S_AXI_TDATA,
    output S_AXI_TVALID,
    output S_AXI_TLAST,
    input  S_AXI_TREADY
  );

  modport slave (
    input  S_AXI_TDATA,
    input  S_AXI_TVALID,
    input  S_AXI_TLAST,
    output S_AXI_TREADY
  );
endinterface

`default_nettype wire

// File: rtl/stream_capture_slave.sv
// ============================================================================
// Module   : stream_capture_slave
// Brief    : Armed single-frame AXI-Stream capture into a dual-port buffer
// Revision : 1.0
// ============================================================================
`default_nettype none

module stream_capture_slave #(
  parameter int DATA_WIDTH        = 32,
  parameter int STORAGE_IDX_WIDTH = 10
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  stream_capture_slave_if.slave             s_axi,
  input  wire logic                         arm,
  input  wire logic [STORAGE_IDX_WIDTH-1:0] rd_addr,
  output logic      [DATA_WIDTH-1:0]        rd_data,
  output logic      [STORAGE_IDX_WIDTH:0]   beat_count,
  output logic                              done,
  output logic                              overflow
);

  localparam int DEPTH = 1 << STORAGE_IDX_WIDTH;
  localparam logic [STORAGE_IDX_WIDTH:0] LAST_IDX = (STORAGE_IDX_WIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  logic   ready;
  logic   accept;
  logic   wr_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ready is a register, so the handshake never depends combinationally on TVALID
  assign s_axi.S_AXI_TREADY = ready;
  assign accept = s_axi.S_AXI_TVALID && ready;
  assign wr_en  = accept && (state == CAPTURE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      beat_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            state      <= CAPTURE;
            ready      <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            beat_count <= '0;
          end
        end
        CAPTURE: begin
          if (accept) begin
            beat_count <= beat_count + 1'b1;
            if (s_axi.S_AXI_TLAST) begin
              state <= DONE;
              ready <= 1'b0;
              done  <= 1'b1;
            end else if (beat_count == LAST_IDX) begin
              state    <= DRAIN;
              overflow <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (accept && s_axi.S_AXI_TLAST) begin
            state <= DONE;
            ready <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Buffer kept free of reset so it maps onto simple dual-port block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[beat_count[STORAGE_IDX_WIDTH-1:0]] <= s_axi.S_AXI_TDATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_capture_slave.sv
// ============================================================================
// Module   : tb_stream_capture_slave
// Brief    : Self-checking bench for stream_capture_slave (8-word buffer)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stream_capture_slave;

  localparam int DW    = 32;
  localparam int SIW   = 3;
  localparam int DEPTH = 1 << SIW;

  logic           clk = 1'b0;
  logic           reset;
  logic           arm;
  logic [SIW-1:0] rd_addr;
  logic [DW-1:0]  rd_data;
  logic [SIW:0]   beat_count;
  logic           done;
  logic           overflow;

  stream_capture_slave_if #(.DATA_WIDTH(DW)) s_if ();

  stream_capture_slave #(
    .DATA_WIDTH       (DW),
    .STORAGE_IDX_WIDTH(SIW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_axi     (s_if.slave),
    .arm       (arm),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .beat_count(beat_count),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference buffer contents: what each slot should hold per frame history
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] fdata [$];

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    chk("arm_ready", DW'(s_if.S_AXI_TREADY), 1);
    chk("arm_done", DW'(done), 0);
    chk("arm_count", DW'(beat_count), 0);
    chk("arm_ovf", DW'(overflow), 0);
  endtask

  task automatic wait_ready();
    int budget = 0;
    while (!s_if.S_AXI_TREADY && budget < 20) begin
      step();
      budget++;
    end
    if (!s_if.S_AXI_TREADY) chk("ready_timeout", 0, 1);
  endtask

  task automatic readback(input int count);
    for (int i = 0; i < count; i++) begin
      rd_addr = SIW'(i);
      step();
      chk($sformatf("rd[%0d]", i), rd_data, exp_mem[i]);
    end
  endtask

  // Drives fdata as one frame; arm pulses alongside beat arm_at (-1 = never)
  task automatic run_frame(input bit gaps, input int arm_at);
    int n;
    int stored;
    n = fdata.size();
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        s_if.S_AXI_TVALID = 1'b0;
        s_if.S_AXI_TDATA  = $urandom;
        repeat ($urandom_range(0, 2)) step();
      end
      s_if.S_AXI_TVALID = 1'b1;
      s_if.S_AXI_TDATA  = fdata[i];
      s_if.S_AXI_TLAST  = (i == n - 1);
      arm = (i == arm_at);
      wait_ready();
      step();
      arm = 1'b0;
      if (i != n - 1) chk("done_early", DW'(done), 0);
    end
    s_if.S_AXI_TVALID = 1'b0;
    s_if.S_AXI_TLAST  = 1'b0;
    stored = (n < DEPTH) ? n : DEPTH;
    for (int i = 0; i < stored; i++) exp_mem[i] = fdata[i];
    chk("done", DW'(done), 1);
    chk("count", DW'(beat_count), DW'(stored));
    chk("ovf", DW'(overflow), DW'(n > DEPTH));
    chk("ready_after", DW'(s_if.S_AXI_TREADY), 0);
    readback(stored);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset             = 1'b1;
    arm               = 1'b0;
    rd_addr           = '0;
    s_if.S_AXI_TVALID = 1'b0;
    s_if.S_AXI_TDATA  = '0;
    s_if.S_AXI_TLAST  = 1'b0;
    repeat (3) step();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ready", DW'(s_if.S_AXI_TREADY), 0);
    chk("rst_done", DW'(done), 0);
    chk("rst_count", DW'(beat_count), 0);
    chk("rst_ovf", DW'(overflow), 0);
    reset = 1'b0;

    // Unarmed: valid data must never be accepted
    s_if.S_AXI_TVALID = 1'b1;
    s_if.S_AXI_TDATA  = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ready", DW'(s_if.S_AXI_TREADY), 0);
    end
    s_if.S_AXI_TVALID = 1'b0;
    chk("idle_done", DW'(done), 0);
    chk("idle_count", DW'(beat_count), 0);

    do_arm();
    fdata = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_frame(1'b0, -1);

    do_arm();
    fdata = '{32'hA, 32'hB, 32'hC};
    run_frame(1'b1, -1);
    do_arm();
    fdata = '{32'h5A5A_0001};
    run_frame(1'b0, -1);

    // Overflow: 10 beats into 8 words
    do_arm();
    fdata.delete();
    for (int i = 0; i < 10; i++) fdata.push_back(i);
    run_frame(1'b0, -1);

    // Exactly DEPTH beats with TLAST on the last one is not an overflow
    do_arm();
    fdata.delete();
    for (int i = 0; i < DEPTH; i++) fdata.push_back(32'h100 + i);
    run_frame(1'b1, -1);

    // arm during a frame is ignored
    do_arm();
    fdata = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4};
    run_frame(1'b0, 2);

    // Reset after two beats of a frame aborts the capture
    do_arm();
    for (int i = 0; i < 2; i++) begin
      s_if.S_AXI_TVALID = 1'b1;
      s_if.S_AXI_TDATA  = 32'hE0 + i;
      s_if.S_AXI_TLAST  = 1'b0;
      step();
      exp_mem[i] = 32'hE0 + i;
    end
    s_if.S_AXI_TDATA = 32'hE2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    s_if.S_AXI_TVALID = 1'b0;
    chk("abort_ready", DW'(s_if.S_AXI_TREADY), 0);
    chk("abort_count", DW'(beat_count), 0);
    chk("abort_done", DW'(done), 0);
    chk("abort_ovf", DW'(overflow), 0);
    step();
    chk("abort_ready2", DW'(s_if.S_AXI_TREADY), 0);
    readback(2);

    // Randomized frames, including overflowing ones and stray arm pulses
    for (int f = 0; f < 25; f++) begin
      do_arm();
      n = $urandom_range(1, 2 * DEPTH);
      fdata.delete();
      for (int i = 0; i < n; i++) fdata.push_back($urandom);
      run_frame(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
